dmem_req_arbiter: RTL
=====================

// Module: dmem_req_arbiter
// PURPOSE
// - Shares mem_controller's dmem read/write ports between NUM_REQ block-read requesters (dcache miss, prefetcher) and one writeback source.
// - Round-robin read arbitration; tracks outstanding reads by block address; routes mem read responses to the owning requester.
// - Buffers writebacks in a FIFO; enforces same-block ordering between reads and writes.
// PARAMETERS
// - NUM_REQ   2  read requesters (power of 2, >=2)
// - OUTST     4  outstanding-read table entries
// - WQ_DEPTH  4  write-queue entries (power of 2)
// PORTS
// - CLK              in   1                   clock
// - RST              in   1                   reset, synchronous, active-high
// - req_valid        in   NUM_REQ             read request per requester
// - req_block_addr   in   NUM_REQ x 13        block_addr_t per requester
// - req_ready        out  NUM_REQ             one-hot grant; accept = valid&&ready
// - resp_valid       out  NUM_REQ             one-hot response to owner
// - resp_block_addr  out  13                  response block address
// - resp_data        out  2x32                word_t [1:0] response block
// - wr_valid         in   1                   writeback request
// - wr_block_addr    in   13                  writeback block address
// - wr_data          in   2x32                writeback block
// - wr_ready         out  1                   !wq_full
// - mem_rd_valid     out  1                   to mem_controller dmem_read_req_valid
// - mem_rd_block_addr out 13                  read address to mem
// - mem_rd_ready     in   1                   mem accepts read this cycle
// - mem_resp_valid   in   1                   from dmem_read_resp_valid
// - mem_resp_block_addr in 13                 from dmem_read_resp_block_addr
// - mem_resp_data    in   2x32                from dmem_read_resp_data
// - mem_wr_valid     out  1                   to dmem_write_req_valid
// - mem_wr_block_addr out 13 ; mem_wr_data out 2x32   write to mem
// - mem_wr_ready     in   1                   mem accepts write this cycle
// - idle             out  1                   wq empty && no outstanding reads
// - error            out  1                   1-cycle pulse: unmatched mem response
// BEHAVIOUR
// - Reset (RST=1 at posedge): table/queue invalid, rr pointer=0, resp_*=0, error=0; combinational outputs (req_ready, wr_ready, mem_*_valid) forced 0 while RST=1.
// - Read eligible: req_valid && table not full && addr not in table && addr not in wq (see macro).
// - One mem request per cycle. Priority: (1) wq full -> write only; (2) eligible read -> read; (3) wq non-empty -> write.
// - Read grant: first eligible requester at/after rr pointer, only when mem_rd_ready; same cycle mem_rd_valid=1, entry {addr,id} allocated, rr pointer <= grant+1 (wraps NUM_REQ-1->0).
// - Write issue: wq head, blocked while table holds same block; dequeue on mem_wr_valid&&mem_wr_ready.
// - Response: mem_resp match in table -> next cycle resp_valid[id]=1 with addr/data, entry freed; no match -> error pulse next cycle, no resp.
// - Latency: grant-to-mem 0 cycles; mem response to resp_valid 1 cycle.
// - Same-cycle write enqueue and read of same block: read compares old wq only, sees pre-write data.
// - Entry freed and new grant same cycle allowed (free visible next cycle only).
// - wq full with wr_valid: wr_ready=0, no enqueue; simultaneous dequeue does not raise wr_ready that cycle.
// CONFIGURATION
// - DMEM_WR_FORWARD_EN defined: read whose addr matches wq (youngest match wins) is granted without mem request or table entry; resp_valid next cycle with wq data; such grant suppressed in any cycle mem_resp_valid=1.
// - Undefined: reads matching wq are held until the write drains.
// STRUCTURE
// - mem_types_pkg: req_id_t, outst_entry_t {valid, block_addr, id}, wq_entry_t {block_addr, data}, defaults for OUTST/WQ_DEPTH.
// - Sub-module dmem_write_queue: FIFO with head/tail wrap, full/empty, addr-match CAM (youngest-hit index).
// TESTING
// - Reset mid-traffic (2 outstanding, wq=3) -> next cycle idle=1, all valid outputs 0, wr_ready=1.
// - req 0 and 1 valid (0x010, 0x020), mem_rd_ready=1 -> grants 0 then 1; resp 0x020 first -> resp_valid=2'b10 next cycle.
// - Both requesters read 0x040 -> only one granted; other held until response frees entry.
// - Write 0x055 queued, read 0x055 -> no mem read until write drains (macro off); macro on: resp data = wr_data next cycle, no mem_rd_valid.
// - Fill wq to 4 -> wr_ready=0, reads stalled, writes drain in FIFO order.
// - mem_resp for 0x1FFF with no entry -> error=1 one cycle, resp_valid=0.

Source files
------------

// File: rtl/mem_types_pkg.sv
// mem_types_pkg: shared block/word types and entry records for the dmem request arbiter.
package mem_types_pkg;
  localparam int NUM_REQ_DEF = 2;
  localparam int OUTST_DEF = 4;
  localparam int WQ_DEPTH_DEF = 4;
  localparam int REQ_ID_W = 4;
  typedef logic [12:0] block_addr_t;
  typedef logic [31:0] word_t;
  typedef logic [REQ_ID_W-1:0] req_id_t;
  typedef struct packed {
    logic valid;
    block_addr_t block_addr;
    req_id_t id;
  } outst_entry_t;
  typedef struct packed {
    block_addr_t block_addr;
    word_t [1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/dmem_write_queue.sv
// dmem_write_queue: writeback FIFO with per-port address CAM reporting the youngest matching entry.
module dmem_write_queue import mem_types_pkg::*; #(
  parameter int DEPTH = WQ_DEPTH_DEF,
  parameter int NQ = NUM_REQ_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic push,
  input  logic pop,
  input  wq_entry_t push_entry,
  output wq_entry_t head,
  output logic full,
  output logic empty,
  input  block_addr_t [NQ-1:0] match_addr,
  output logic [NQ-1:0] hit,
  output word_t [NQ-1:0][1:0] hit_data
);
  localparam int AW = $clog2(DEPTH);
  wq_entry_t q [DEPTH];
  logic [AW-1:0] hd, tl;
  logic [AW:0] cnt;
  assign head = q[hd];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      hd <= '0;
      tl <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        q[tl] <= push_entry;
        tl <= tl + 1'b1;
      end
      if (pop) hd <= hd + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // scan oldest to youngest so the last hit left standing is the youngest
  always_comb begin
    hit = '0;
    hit_data = '0;
    for (int n = 0; n < NQ; n++)
      for (int k = 0; k < DEPTH; k++)
        if ((AW+1)'(k) < cnt && q[hd + AW'(k)].block_addr == match_addr[n]) begin
          hit[n] = 1'b1;
          hit_data[n] = q[hd + AW'(k)].data;
        end
  end
endmodule

// File: rtl/dmem_req_arbiter.sv
// dmem_req_arbiter: round-robin block-read arbitration plus writeback FIFO sharing the dmem ports.
// Define DMEM_WR_FORWARD_EN to serve reads that hit the write queue directly from queued data.
module dmem_req_arbiter import mem_types_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int OUTST = OUTST_DEF,
  parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic [NUM_REQ-1:0] req_valid,
  input  block_addr_t [NUM_REQ-1:0] req_block_addr,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] resp_valid,
  output block_addr_t resp_block_addr,
  output word_t [1:0] resp_data,
  input  logic wr_valid,
  input  block_addr_t wr_block_addr,
  input  word_t [1:0] wr_data,
  output logic wr_ready,
  output logic mem_rd_valid,
  output block_addr_t mem_rd_block_addr,
  input  logic mem_rd_ready,
  input  logic mem_resp_valid,
  input  block_addr_t mem_resp_block_addr,
  input  word_t [1:0] mem_resp_data,
  output logic mem_wr_valid,
  output block_addr_t mem_wr_block_addr,
  output word_t [1:0] mem_wr_data,
  input  logic mem_wr_ready,
  output logic idle,
  output logic error
);
  localparam int RW = $clog2(NUM_REQ);
  localparam int TW = $clog2(OUTST);
  outst_entry_t tbl [OUTST];
  logic [NUM_REQ-1:0] in_tbl, wq_hit, cand_mem, cand_fwd, cand;
  word_t [NUM_REQ-1:0][1:0] wq_hit_data;
  logic [RW-1:0] rr, gnt;
  logic [TW-1:0] free_idx, rsp_idx;
  logic found, rd_go, fwd_go, tbl_full, head_blk, any_out, rsp_hit;
  logic push, pop, wq_full, wq_empty;
  wq_entry_t wq_in, wq_head;
  assign wq_in = '{block_addr: wr_block_addr, data: wr_data};
  dmem_write_queue #(.DEPTH(WQ_DEPTH), .NQ(NUM_REQ)) u_wq (
    .CLK(CLK), .RST(RST), .push(push), .pop(pop), .push_entry(wq_in), .head(wq_head),
    .full(wq_full), .empty(wq_empty), .match_addr(req_block_addr), .hit(wq_hit),
    .hit_data(wq_hit_data)
  );
  always_comb begin
    in_tbl = '0;
    tbl_full = 1'b1;
    any_out = 1'b0;
    head_blk = 1'b0;
    rsp_hit = 1'b0;
    rsp_idx = '0;
    free_idx = '0;
    for (int i = OUTST-1; i >= 0; i--) begin
      if (!tbl[i].valid) begin
        tbl_full = 1'b0;
        free_idx = TW'(i);
      end
      any_out = any_out | tbl[i].valid;
      head_blk = head_blk | (tbl[i].valid && tbl[i].block_addr == wq_head.block_addr);
      if (tbl[i].valid && tbl[i].block_addr == mem_resp_block_addr) begin
        rsp_hit = mem_resp_valid;
        rsp_idx = TW'(i);
      end
      for (int r = 0; r < NUM_REQ; r++)
        in_tbl[r] = in_tbl[r] | (tbl[i].valid && tbl[i].block_addr == req_block_addr[r]);
    end
  end
  // a forwarded grant needs the response register, so it yields to memory responses
  always_comb begin
    cand_mem = req_valid & ~in_tbl & ~wq_hit & {NUM_REQ{mem_rd_ready && !wq_full && !tbl_full}};
`ifdef DMEM_WR_FORWARD_EN
    cand_fwd = req_valid & ~in_tbl & wq_hit & {NUM_REQ{!mem_resp_valid}};
`else
    cand_fwd = '0;
`endif
    cand = RST ? '0 : cand_mem | cand_fwd;
    found = 1'b0;
    gnt = rr;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (cand[RW'(rr + RW'(k))]) begin
        found = 1'b1;
        gnt = RW'(rr + RW'(k));
      end
    fwd_go = found && cand_fwd[gnt];
    rd_go = found && !cand_fwd[gnt];
    req_ready = found ? NUM_REQ'(1) << gnt : '0;
  end
  assign mem_rd_valid = rd_go;
  assign mem_rd_block_addr = req_block_addr[gnt];
  assign mem_wr_valid = !RST && !wq_empty && !head_blk && !rd_go;
  assign mem_wr_block_addr = wq_head.block_addr;
  assign mem_wr_data = wq_head.data;
  assign wr_ready = !RST && !wq_full;
  assign push = wr_valid && wr_ready;
  assign pop = mem_wr_valid && mem_wr_ready;
  assign idle = wq_empty && !any_out;
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr <= '0;
      resp_valid <= '0;
      resp_block_addr <= '0;
      resp_data <= '0;
      error <= 1'b0;
      for (int i = 0; i < OUTST; i++) tbl[i] <= '0;
    end else begin
      error <= mem_resp_valid && !rsp_hit;
      resp_valid <= rsp_hit ? NUM_REQ'(1) << tbl[rsp_idx].id : fwd_go ? NUM_REQ'(1) << gnt : '0;
      if (rsp_hit) begin
        resp_block_addr <= mem_resp_block_addr;
        resp_data <= mem_resp_data;
      end else if (fwd_go) begin
        resp_block_addr <= req_block_addr[gnt];
        resp_data <= wq_hit_data[gnt];
      end
      if (found) rr <= gnt + 1'b1;
      if (rsp_hit) tbl[rsp_idx].valid <= 1'b0;
      if (rd_go) tbl[free_idx] <= '{valid: 1'b1, block_addr: req_block_addr[gnt], id: req_id_t'(gnt)};
    end
  end
endmodule
